// File: rtl/vi_pkg.sv
// Shared types and defaults for the video line-capture block.
package vi_pkg;

    localparam int CAP_LEN_W = 12;
    localparam int DATA_W    = 16;
    localparam int DEPTH_DEF = 2048;
    localparam int AW_DEF    = 11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_LINE = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_READY     = 3'd4,
        ST_READOUT   = 3'd5
    } cap_state_t;

endpackage

// File: rtl/vi_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
module vi_line_ram
    import vi_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [AW-1:0]     ra,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) q <= mem[ra];
    end

endmodule

// File: rtl/vi_line_capture.sv
// Freezes one active line of a field into line RAM and drains it word by word.
// Optional running checksum of stored words is enabled by VI_CAP_CHECKSUM_EN.
//
// state     | meaning
// IDLE      | waiting for cap_req
// ARM       | armed, waiting for a fresh field (vsync_ad)
// WAIT_LINE | waiting for first dvalid word of the target line
// CAPTURE   | storing words of the target line
// READY     | line frozen, no word read yet
// READOUT   | draining stored words
module vi_line_capture
    import vi_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = AW_DEF,
    parameter int X_SKIP = 0
) (
    input  logic                 vp_clk_in,
    input  logic                 sys_rst_n,
    input  logic                 vsync_ad,
    input  logic                 vsync_flag,
    input  logic                 dvalid_flag,
    input  logic [10:0]          y,
    input  logic [DATA_W-1:0]    video_data,
    input  logic                 cap_req,
    input  logic [10:0]          cap_line,
    input  logic                 cap_abort,
    input  logic                 rd_en,
    output logic                 cap_busy,
    output logic                 cap_done,
    output logic                 cap_err,
    output logic                 cap_ovf,
    output logic [CAP_LEN_W-1:0] cap_len,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 rd_last,
    output logic [DATA_W-1:0]    cap_sum
);

    localparam logic [CAP_LEN_W-1:0] DEPTH_L = CAP_LEN_W'(DEPTH);
    localparam logic [CAP_LEN_W-1:0] SKIP_L  = CAP_LEN_W'(X_SKIP);
    localparam logic [CAP_LEN_W-1:0] ONE     = CAP_LEN_W'(1);

    cap_state_t           state;
    logic [10:0]          target;
    logic [CAP_LEN_W-1:0] rptr;
    logic [CAP_LEN_W-1:0] skip_left;
    logic                 rd_empty;
    logic [DATA_W-1:0]    ram_q;

    logic line_hit, cap_word, skipping, store, rd_accept;

    always_comb begin
        line_hit  = (state == ST_WAIT_LINE) && vsync_flag && dvalid_flag && (y == target);
        cap_word  = line_hit || ((state == ST_CAPTURE) && dvalid_flag);
        skipping  = (state == ST_WAIT_LINE) ? (SKIP_L != '0) : (skip_left != '0);
        store     = cap_word && !skipping && (cap_len != DEPTH_L) && !cap_abort && !vsync_ad;
        rd_accept = ((state == ST_READY) || (state == ST_READOUT)) && rd_en
                    && (rptr != cap_len) && !cap_abort;
    end

    vi_line_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk (vp_clk_in),
        .we  (store),
        .wa  (cap_len[AW-1:0]),
        .wd  (video_data),
        .re  (rd_accept),
        .ra  (rptr[AW-1:0]),
        .q   (ram_q)
    );

    always_ff @(posedge vp_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            target    <= '0;
            cap_len   <= '0;
            cap_ovf   <= 1'b0;
            cap_err   <= 1'b0;
            rptr      <= '0;
            skip_left <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_empty  <= 1'b0;
        end else begin
            cap_err  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_empty <= 1'b0;
            if (cap_abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (cap_req) begin
                        target  <= cap_line;
                        cap_len <= '0;
                        cap_ovf <= 1'b0;
                        rptr    <= '0;
                        state   <= ST_ARM;
                    end
                    ST_ARM: if (vsync_ad) state <= ST_WAIT_LINE;
                    ST_WAIT_LINE: begin
                        if (vsync_ad) begin
                            cap_err <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (line_hit) begin
                            state     <= ST_CAPTURE;
                            skip_left <= skipping ? SKIP_L - ONE : '0;
                            if (store) cap_len <= cap_len + ONE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (vsync_ad) begin
                            cap_err <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (!dvalid_flag) begin
                            state <= ST_READY;
                        end else if (skipping) begin
                            skip_left <= skip_left - ONE;
                        end else if (store) begin
                            cap_len <= cap_len + ONE;
                        end else begin
                            cap_ovf <= 1'b1;
                        end
                    end
                    ST_READY, ST_READOUT: begin
                        // An empty capture still hands the reader one terminating word.
                        if ((state == ST_READY) && rd_en && (cap_len == '0)) begin
                            rd_valid <= 1'b1;
                            rd_last  <= 1'b1;
                            rd_empty <= 1'b1;
                            state    <= ST_IDLE;
                        end else if (rd_accept) begin
                            rd_valid <= 1'b1;
                            rd_last  <= (rptr == cap_len - ONE);
                            rptr     <= rptr + ONE;
                            state    <= ST_READOUT;
                        end else if (rd_last) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign cap_busy = (state == ST_ARM) || (state == ST_WAIT_LINE) || (state == ST_CAPTURE);
    assign cap_done = (state == ST_READY) || (state == ST_READOUT);
    assign rd_data  = (rd_valid && !rd_empty) ? ram_q : '0;

`ifdef VI_CAP_CHECKSUM_EN
    always_ff @(posedge vp_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cap_sum <= '0;
        end else if ((state == ST_IDLE) && cap_req && !cap_abort) begin
            cap_sum <= '0;
        end else if (store) begin
            cap_sum <= cap_sum + video_data;
        end
    end
`else
    assign cap_sum = '0;
`endif

endmodule

// File: tb/tb_vi_line_capture.sv
// Directed scoreboard bench for vi_line_capture (default DEPTH=2048, X_SKIP=0).
module tb_vi_line_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync_ad = 1'b0, vsync_flag = 1'b0, dvalid_flag = 1'b0;
    logic [10:0] y = '0;
    logic [15:0] video_data = '0;
    logic        cap_req = 1'b0;
    logic [10:0] cap_line = '0;
    logic        cap_abort = 1'b0, rd_en = 1'b0;
    logic        cap_busy, cap_done, cap_err, cap_ovf, rd_valid, rd_last;
    logic [11:0] cap_len;
    logic [15:0] rd_data, cap_sum;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_sum;
    bit          done_seen;
    logic [15:0] cust [4];

    always #5 clk = ~clk;

    vi_line_capture dut (
        .vp_clk_in(clk), .sys_rst_n(rst_n), .vsync_ad(vsync_ad), .vsync_flag(vsync_flag),
        .dvalid_flag(dvalid_flag), .y(y), .video_data(video_data), .cap_req(cap_req),
        .cap_line(cap_line), .cap_abort(cap_abort), .rd_en(rd_en), .cap_busy(cap_busy),
        .cap_done(cap_done), .cap_err(cap_err), .cap_ovf(cap_ovf), .cap_len(cap_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .cap_sum(cap_sum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (cap_done) done_seen = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cap_sum();
`ifdef VI_CAP_CHECKSUM_EN
        return exp_sum;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic request(input logic [10:0] line);
        cap_req  = 1'b1;
        cap_line = line;
        tick();
        cap_req  = 1'b0;
        chk("req_busy", cap_busy, 1);
        chk("req_len_clr", cap_len, 0);
        chk("req_ovf_clr", cap_ovf, 0);
    endtask

    // One field; words of the target line (up to RAM depth) go to the scoreboard.
    task automatic drive_field(input int nlines, input int nwords, input int target,
                               input int abort_at, input bit custom);
        exp_sum  = '0;
        vsync_ad = 1'b1;
        tick();
        vsync_ad = 1'b0;
        repeat (4) tick();
        vsync_flag = 1'b1;
        for (int l = 0; l < nlines; l++) begin
            y = 11'(l);
            for (int x = 0; x < nwords; x++) begin
                dvalid_flag = 1'b1;
                video_data  = custom ? cust[x % 4] : 16'h1000 + 16'(x);
                if (l == target && x < 2048 && abort_at < 0) begin
                    exp_q.push_back(video_data);
                    exp_sum = exp_sum + video_data;
                end
                cap_abort = (l == target && x == abort_at);
                tick();
                if (cap_abort) begin
                    cap_abort = 1'b0;
                    chk("abort_busy", cap_busy, 0);
                    chk("abort_done", cap_done, 0);
                end
            end
            dvalid_flag = 1'b0;
            repeat (8) tick();
        end
        vsync_flag = 1'b0;
        y = '0;
        repeat (4) tick();
    endtask

    task automatic readout(input int n, input bit gaps, input string tag);
        int got = 0;
        logic [15:0] e;
        for (int c = 0; c < 2 * n + 8; c++) begin
            rd_en = gaps ? (c % 2 == 0) : 1'b1;
            tick();
            if (rd_valid) begin
                chk({tag, "_no_extra"}, exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk({tag, "_data"}, rd_data, e);
                    chk({tag, "_last"}, rd_last, got == n - 1);
                end
                got++;
            end
        end
        rd_en = 1'b0;
        chk({tag, "_count"}, got, n);
        chk({tag, "_idle"}, {cap_busy, cap_done}, 0);
    endtask

    initial begin
        cust[0] = 16'h0001; cust[1] = 16'h0002; cust[2] = 16'hFFFF; cust[3] = 16'h0010;
        repeat (3) tick();
        chk("rst_outs", {cap_busy, cap_done, cap_err, cap_ovf, rd_valid, rd_last}, 0);
        chk("rst_len", cap_len, 0);
        chk("rst_sum", cap_sum, 0);
        rst_n = 1'b1;
        tick();

        // req with abort in the same cycle stays idle
        cap_req = 1'b1; cap_abort = 1'b1; cap_line = 11'd3;
        tick();
        cap_req = 1'b0; cap_abort = 1'b0;
        chk("req_abort_idle", cap_busy, 0);

        // 1 + 5: full 1920-word line, burst readout with trailing rd_en
        request(11'd3);
        drive_field(8, 1920, 3, -1, 1'b0);
        chk("t1_len", cap_len, 1920);
        chk("t1_done", {cap_busy, cap_done}, 2'b01);
        chk("t1_sum", cap_sum, exp_cap_sum());
        readout(1920, 1'b0, "t1");

        // 2: target beyond field
        done_seen = 1'b0;
        request(11'd10);
        drive_field(8, 16, 10, -1, 1'b0);
        chk("t2_waiting", cap_busy, 1);
        vsync_ad = 1'b1;
        tick();
        vsync_ad = 1'b0;
        chk("t2_err", cap_err, 1);
        chk("t2_idle", cap_busy, 0);
        tick();
        chk("t2_err_pulse", cap_err, 0);
        chk("t2_no_done", done_seen, 0);

        // 3: overflow
        request(11'd1);
        drive_field(3, 2100, 1, -1, 1'b0);
        chk("t3_ovf", cap_ovf, 1);
        chk("t3_len", cap_len, 2048);
        chk("t3_sum", cap_sum, exp_cap_sum());
        chk("t3_last_word_exp", exp_q[2047], 16'h1000 + 16'd2047);
        readout(2048, 1'b0, "t3");

        // 4: abort mid-capture, then a fresh capture with gapped readout
        request(11'd1);
        drive_field(4, 600, 1, 500, 1'b0);
        chk("t4_still_idle", {cap_busy, cap_done}, 0);
        request(11'd2);
        drive_field(4, 32, 2, -1, 1'b0);
        chk("t4_len", cap_len, 32);
        chk("t4_ovf", cap_ovf, 0);
        readout(32, 1'b1, "t4");

        // 6: checksum wrap
        request(11'd0);
        drive_field(2, 4, 0, -1, 1'b1);
        chk("t6_len", cap_len, 4);
`ifdef VI_CAP_CHECKSUM_EN
        chk("t6_sum", cap_sum, 16'h0012);
`else
        chk("t6_sum", cap_sum, 16'h0000);
`endif
        readout(4, 1'b0, "t6");

        // reset mid-capture
        request(11'd0);
        vsync_ad = 1'b1; tick(); vsync_ad = 1'b0;
        vsync_flag = 1'b1; dvalid_flag = 1'b1; video_data = 16'h5555;
        repeat (3) tick();
        chk("mid_busy", cap_busy, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_outs", {cap_busy, cap_done, cap_err, cap_ovf, rd_valid, rd_last}, 0);
        chk("mid_rst_len", cap_len, 0);
        vsync_flag = 1'b0; dvalid_flag = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
